// File: rtl/fifo_nword_pkg.sv
// Shared sizing helpers, thresholds and error-flag payload for the N-word FWFT FIFO.
package fifo_nword_pkg;

  localparam int unsigned DEF_AE_LEVEL  = 1;
  localparam int unsigned DEF_AF_MARGIN = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Width of the occupancy count, which must be able to represent depth itself.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Store pointer width; a one-entry store still needs a one-bit pointer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth - 1 <= 1) ? 1 : $clog2(depth - 1);
  endfunction

endpackage

// File: rtl/fifo_nword_store.sv
// (depth-1)-entry register array: clocked write port, asynchronous read port.
module fifo_nword_store #(
  parameter int unsigned bits    = 8,
  parameter int unsigned entries = 7,
  parameter int unsigned aw      = 3
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [aw-1:0]   wr_addr,
  input  logic [bits-1:0] wr_data,
  input  logic [aw-1:0]   rd_addr,
  output logic [bits-1:0] rd_data
);

  logic [bits-1:0] r_mem [entries];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/fifo_nword_fwft.sv
// First-word-fall-through FIFO: head register plus circular store, level and threshold flags.
// Optional sticky overflow/underflow flags with err_clr when FIFO_NWORD_ERR_FLAGS_EN is defined.
module fifo_nword_fwft
  import fifo_nword_pkg::*;
#(
  parameter int unsigned bits     = 8,
  parameter int unsigned depth    = 8,
  parameter int unsigned af_level = depth - DEF_AF_MARGIN,
  parameter int unsigned ae_level = DEF_AE_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     shift_in,
  input  logic                     shift_out,
  input  logic [bits-1:0]          data_in,
  output logic [bits-1:0]          data_out,
  output logic                     fifo_not_empty,
  output logic                     fifo_full,
  output logic [lvl_w(depth)-1:0]  level,
  output logic                     almost_full,
`ifdef FIFO_NWORD_ERR_FLAGS_EN
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic                     almost_empty
);

  localparam int unsigned LW = lvl_w(depth);
  localparam int unsigned PW = ptr_w(depth);

  logic [bits-1:0] r_head;
  logic            r_not_empty;
  logic [LW-1:0]   r_level;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            r_af;
  logic            r_ae;

  logic            w_full;
  logic            w_in_ok;
  logic            w_out_ok;
  logic            w_store_empty;
  logic            w_wr_en;
  logic [bits-1:0] w_rd_data;
  logic [bits-1:0] w_head_nxt;
  logic            w_not_empty_nxt;
  logic [LW-1:0]   w_level_nxt;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 2)) ? '0 : p + PW'(1);
  endfunction

  fifo_nword_store #(
    .bits    (bits),
    .entries (depth - 1),
    .aw      (PW)
  ) u_store (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wptr),
    .wr_data (data_in),
    .rd_addr (r_rptr),
    .rd_data (w_rd_data)
  );

  // A full FIFO still accepts a word when the head is consumed in the same cycle.
  assign w_full        = (r_level == LW'(depth)) && !shift_out;
  assign w_in_ok       = shift_in && !w_full;
  assign w_out_ok      = shift_out && r_not_empty;
  assign w_store_empty = (r_level <= LW'(1));

  // Next head/pointer/level; new words bypass the store whenever the head is free.
  always_comb begin
    w_head_nxt      = r_head;
    w_not_empty_nxt = r_not_empty;
    w_wr_en         = 1'b0;
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_level_nxt     = r_level;

    if (!r_not_empty) begin
      if (w_in_ok) begin
        w_head_nxt      = data_in;
        w_not_empty_nxt = 1'b1;
      end
    end else if (w_out_ok) begin
      if (w_store_empty) begin
        if (w_in_ok) w_head_nxt = data_in;
        else         w_not_empty_nxt = 1'b0;
      end else begin
        w_head_nxt = w_rd_data;
        w_rptr_nxt = ptr_inc(r_rptr);
        if (w_in_ok) begin
          w_wr_en    = 1'b1;
          w_wptr_nxt = ptr_inc(r_wptr);
        end
      end
    end else if (w_in_ok) begin
      w_wr_en    = 1'b1;
      w_wptr_nxt = ptr_inc(r_wptr);
    end

    unique case ({w_in_ok, w_out_ok})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_not_empty <= 1'b0;
      r_level     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_af        <= 1'b0;
      r_ae        <= 1'b1;
    end else begin
      r_head      <= w_head_nxt;
      r_not_empty <= w_not_empty_nxt;
      r_level     <= w_level_nxt;
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_af        <= (w_level_nxt >= LW'(af_level));
      r_ae        <= (w_level_nxt <= LW'(ae_level));
    end
  end

`ifdef FIFO_NWORD_ERR_FLAGS_EN
  fifo_err_t r_err;

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= '0;
    end else begin
      if (err_clr) r_err <= '0;
      if (shift_in && w_full)       r_err.overflow  <= 1'b1;
      if (shift_out && !r_not_empty) r_err.underflow <= 1'b1;
    end
  end

  assign overflow  = r_err.overflow;
  assign underflow = r_err.underflow;
`endif

  assign data_out       = r_head;
  assign fifo_not_empty = r_not_empty;
  assign fifo_full      = w_full;
  assign level          = r_level;
  assign almost_full    = r_af;
  assign almost_empty   = r_ae;

endmodule

// File: tb/tb_fifo_nword_fwft.sv
// Randomised bench for fifo_nword_fwft against a queue-based reference model.
module tb_fifo_nword_fwft;

  localparam int unsigned BITS  = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            shift_in = 1'b0;
  logic            shift_out = 1'b0;
  logic [BITS-1:0] data_in = '0;
  logic [BITS-1:0] data_out;
  logic            fifo_not_empty;
  logic            fifo_full;
  logic [3:0]      level;
  logic            almost_full;
  logic            almost_empty;
`ifdef FIFO_NWORD_ERR_FLAGS_EN
  logic            err_clr = 1'b0;
  logic            overflow;
  logic            underflow;
  logic            exp_ovf = 1'b0;
  logic            exp_unf = 1'b0;
`endif

  logic [BITS-1:0] q[$];
  logic [BITS-1:0] exp_dout = '0;
  int              n_checks = 0;
  int              n_pass   = 0;

  fifo_nword_fwft #(.bits(BITS), .depth(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .shift_in       (shift_in),
    .shift_out      (shift_out),
    .data_in        (data_in),
    .data_out       (data_out),
    .fifo_not_empty (fifo_not_empty),
    .fifo_full      (fifo_full),
    .level          (level),
    .almost_full    (almost_full),
`ifdef FIFO_NWORD_ERR_FLAGS_EN
    .err_clr        (err_clr),
    .overflow       (overflow),
    .underflow      (underflow),
`endif
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("fifo_not_empty", 32'(fifo_not_empty), 32'(sz != 0));
    chk("level", 32'(level), 32'(sz));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
`ifdef FIFO_NWORD_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of stimulus; called 1 time unit after a rising edge.
  task automatic step(input logic si, input logic so, input logic [BITS-1:0] din);
    logic exp_full;
    logic acc_in;
    logic acc_out;
    shift_in  = si;
    shift_out = so;
    data_in   = din;
    #1;
    exp_full = (q.size() == DEPTH) && !so;
    chk("fifo_full", 32'(fifo_full), 32'(exp_full));
    acc_in  = si && !exp_full;
    acc_out = so && (q.size() != 0);
`ifdef FIFO_NWORD_ERR_FLAGS_EN
    if (err_clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end
    if (si && exp_full)      exp_ovf = 1'b1;
    if (so && q.size() == 0) exp_unf = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (acc_out) void'(q.pop_front());
    if (acc_in)  q.push_back(din);
    if (q.size() != 0) exp_dout = q[0];
    check_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    shift_in  = 1'b0;
    shift_out = 1'b0;
    #2;
    reset_n = 1'b0;
    q.delete();
    exp_dout = '0;
`ifdef FIFO_NWORD_ERR_FLAGS_EN
    err_clr = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    int p_in [4] = '{70, 30, 50, 90};
    int p_out[4] = '{30, 70, 50, 90};

    do_reset();

    step(1'b1, 1'b0, 8'hA5);
    drain();

    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'(i));
    drain();

    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'h10 + i));
    drain();

    step(1'b0, 1'b1, 8'h00);
`ifdef FIFO_NWORD_ERR_FLAGS_EN
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    step(1'b0, 1'b0, 8'h00);
`endif

    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'h33);
    drain();

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    do_reset();

    for (int ph = 0; ph < 12; ph++) begin
      for (int c = 0; c < 250; c++) begin
`ifdef FIFO_NWORD_ERR_FLAGS_EN
        err_clr = ($urandom_range(0, 19) == 0);
`endif
        step(1'($urandom_range(0, 99) < p_in[ph % 4]),
             1'($urandom_range(0, 99) < p_out[ph % 4]),
             8'($urandom));
      end
      if (ph == 6) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
